fetch_stream_source: RTL and testbench

- Producer (initiator) end of the valid/ready stream interface used between pipeline stages.
- Generates sequential PCs, issues reads to a synchronous instruction memory with 1-cycle read latency, and presents {pc, instr} packets downstream under valid/ready.
- Holds packets while downstream stalls, with no loss or duplication.
- Supports redirects (branch/flush) that discard all buffered and in-flight fetches.

---
 rtl/fetch_stream_source_if.sv | 25 ++
 rtl/fetch_stream_source.sv | 82 ++++++++
 tb/tb_fetch_stream_source.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stream_source_if.sv
// Stream/fetch bus bundle for fetch_stream_source: instruction-memory read port,
// redirect request and the downstream {pc, instr} valid/ready stream.
interface fetch_stream_source_if #(
    parameter int XLEN = 32
);
    logic            imem_en;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            valid_out;
    logic            ready_out;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] instr_out;

    modport master (
        output imem_en, imem_addr, valid_out, pc_out, instr_out,
        input  imem_rdata, redirect_valid, redirect_pc, ready_out
    );

    modport slave (
        input  imem_en, imem_addr, valid_out, pc_out, instr_out,
        output imem_rdata, redirect_valid, redirect_pc, ready_out
    );
endinterface

// File: rtl/fetch_stream_source.sv
// Sequential-PC fetch unit: issues reads to a 1-cycle-latency instruction memory and
// streams {pc, instr} packets through a 2-entry output FIFO, with redirect flush.
module fetch_stream_source #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    fetch_stream_source_if.master bus
);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [XLEN-1:0] buf_pc    [2];
    logic [XLEN-1:0] buf_instr [2];
    logic            rd_ptr;
    logic [1:0]      count;

    logic            pop;
    logic            push;
    logic            issue;
    logic            wr_ptr;
    logic [2:0]      occupancy;

    // count + inflight never exceeds 2, so a push can never land on a full FIFO.
    always_comb begin
        occupancy = {1'b0, count} + {2'b00, inflight};
        pop       = (count != 2'd0) && bus.ready_out;
        issue     = !reset && !bus.redirect_valid && ((occupancy < 3'd2) || pop);
        push      = inflight && !bus.redirect_valid;
        wr_ptr    = rd_ptr ^ count[0];
    end

    assign bus.imem_en   = issue;
    assign bus.imem_addr = fetch_pc;
    assign bus.valid_out = (count != 2'd0);
    assign bus.pc_out    = buf_pc[rd_ptr];
    assign bus.instr_out = buf_instr[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc    <= RESET_PC & ALIGN_MASK;
            inflight_pc <= '0;
            inflight    <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                buf_pc[i]    <= '0;
                buf_instr[i] <= '0;
            end
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
            end
            if (bus.redirect_valid) begin
                // Flush buffered packets; the in-flight response is dropped via push.
                fetch_pc <= bus.redirect_pc & ALIGN_MASK;
                count    <= 2'd0;
                rd_ptr   <= 1'b0;
            end else begin
                if (issue) begin
                    fetch_pc <= fetch_pc + XLEN'(4);
                end
                if (push) begin
                    buf_pc[wr_ptr]    <= inflight_pc;
                    buf_instr[wr_ptr] <= bus.imem_rdata;
                end
                if (pop) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fetch_stream_source.sv
// Directed bench for fetch_stream_source: streaming, stall, redirects, wrap and async reset,
// against a registered instruction-memory model.
module tb_fetch_stream_source;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    localparam logic [32:0] OFF = 33'h0;

    fetch_stream_source_if #(.XLEN(32)) bus ();

    fetch_stream_source #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [32:0] on(input logic [31:0] a);
        return {1'b1, a};
    endfunction

    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= instr_of(bus.imem_addr);
    end

    task automatic do_reset();
        reset = 1'b1;
        bus.ready_out = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if ({bus.valid_out, bus.imem_en, bus.pc_out, bus.instr_out} !== 66'h0)
            $display("FAIL reset_values got valid=%b en=%b pc=%h instr=%h expected all zero",
                     bus.valid_out, bus.imem_en, bus.pc_out, bus.instr_out);
        else pass_cnt++;
    endtask

    task automatic test_stream();
        logic [32:0] ee [6];
        logic [32:0] ep [6];
        ee = '{on(32'h0), on(32'h4), on(32'h8), on(32'hC), on(32'h10), on(32'h14)};
        ep = '{OFF, OFF, on(32'h0), on(32'h4), on(32'h8), on(32'hC)};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = 1'b1;
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL stream_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL stream_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        logic [32:0] ee [13];
        logic [32:0] ep [13];
        ee = '{on(32'h0), on(32'h4), on(32'h8), on(32'hC), OFF, OFF, OFF, OFF, OFF,
               on(32'h10), on(32'h14), on(32'h18), on(32'h1C)};
        ep = '{OFF, OFF, on(32'h0), on(32'h4), on(32'h8), on(32'h8), on(32'h8), on(32'h8),
               on(32'h8), on(32'h8), on(32'hC), on(32'h10), on(32'h14)};
        do_reset();
        for (int c = 0; c < 13; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = !(c >= 4 && c <= 8);
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL stall_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL stall_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
        bus.ready_out = 1'b1;
    endtask

    task automatic test_redirect_full();
        logic [32:0] ee [12];
        logic [32:0] ep [12];
        ee = '{on(32'h0), on(32'h4), on(32'h8), on(32'hC), OFF, OFF, OFF, OFF,
               on(32'h100), on(32'h104), on(32'h108), on(32'h10C)};
        ep = '{OFF, OFF, on(32'h0), on(32'h4), on(32'h8), on(32'h8), on(32'h8), on(32'h8),
               OFF, OFF, on(32'h100), on(32'h104)};
        do_reset();
        for (int c = 0; c < 12; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = !(c >= 4 && c <= 7);
            bus.redirect_valid = (c == 7);
            bus.redirect_pc = 32'h103;
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL redir_full_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL redir_full_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
        bus.redirect_valid = 1'b0;
        bus.ready_out = 1'b1;
    endtask

    task automatic test_redirect_pop();
        logic [32:0] ee [9];
        logic [32:0] ep [9];
        ee = '{on(32'h0), on(32'h4), on(32'h8), on(32'hC), OFF,
               on(32'h200), on(32'h204), on(32'h208), on(32'h20C)};
        ep = '{OFF, OFF, on(32'h0), on(32'h4), on(32'h8), OFF, OFF, on(32'h200), on(32'h204)};
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = 1'b1;
            bus.redirect_valid = (c == 4);
            bus.redirect_pc = 32'h200;
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL redir_pop_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL redir_pop_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [32:0] ee [10];
        logic [32:0] ep [10];
        ee = '{on(32'h0), on(32'h4), on(32'h8), on(32'hC), OFF, OFF,
               on(32'h404), on(32'h408), on(32'h40C), on(32'h410)};
        ep = '{OFF, OFF, on(32'h0), on(32'h4), on(32'h8), OFF, OFF, OFF,
               on(32'h404), on(32'h408)};
        do_reset();
        for (int c = 0; c < 10; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = 1'b1;
            bus.redirect_valid = (c == 4 || c == 5);
            bus.redirect_pc = (c == 4) ? 32'h300 : 32'h407;
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL b2b_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL b2b_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_wrap();
        logic [32:0] ee [7];
        logic [32:0] ep [7];
        ee = '{OFF, on(32'hFFFF_FFF8), on(32'hFFFF_FFFC), on(32'h0), on(32'h4),
               on(32'h8), on(32'hC)};
        ep = '{OFF, OFF, OFF, on(32'hFFFF_FFF8), on(32'hFFFF_FFFC), on(32'h0), on(32'h4)};
        do_reset();
        for (int c = 0; c < 7; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = 1'b1;
            bus.redirect_valid = (c == 0);
            bus.redirect_pc = 32'hFFFF_FFF8;
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL wrap_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL wrap_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
        bus.redirect_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [32:0] ee [4];
        logic [32:0] ep [4];
        ee = '{on(32'h0), on(32'h4), on(32'h8), on(32'hC)};
        ep = '{OFF, OFF, on(32'h0), on(32'h4)};
        do_reset();
        repeat (5) @(negedge clk);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        total_cnt++;
        if ({bus.valid_out, bus.imem_en, bus.pc_out, bus.instr_out} !== 66'h0)
            $display("FAIL async_reset_drop got valid=%b en=%b pc=%h instr=%h expected all zero",
                     bus.valid_out, bus.imem_en, bus.pc_out, bus.instr_out);
        else pass_cnt++;
        do_reset();
        for (int c = 0; c < 4; c++) begin
            if (c != 0) @(negedge clk);
            bus.ready_out = 1'b1;
            #1;
            total_cnt++;
            if (bus.imem_en !== ee[c][32] || (ee[c][32] && bus.imem_addr !== ee[c][31:0]))
                $display("FAIL async_restart_issue c=%0d got en=%b addr=%h expected en=%b addr=%h",
                         c, bus.imem_en, bus.imem_addr, ee[c][32], ee[c][31:0]);
            else pass_cnt++;
            total_cnt++;
            if (bus.valid_out !== ep[c][32] || (ep[c][32] &&
                (bus.pc_out !== ep[c][31:0] || bus.instr_out !== instr_of(ep[c][31:0]))))
                $display("FAIL async_restart_packet c=%0d got v=%b pc=%h instr=%h expected v=%b pc=%h",
                         c, bus.valid_out, bus.pc_out, bus.instr_out, ep[c][32], ep[c][31:0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        reset = 1'b1;
        bus.ready_out = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
